// File: rtl/wb_gpio_ctrl.sv
// Wishbone GPIO block: 38 pad outputs/enables, synchronized inputs and rising-edge interrupts.
// Single-cycle ack one clock after select (2 cycles per transfer). No wait states beyond that; io_active gates the pads.
module wb_gpio_ctrl #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          NIO      = 38
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            io_active,
  input  logic [NIO-1:0]  io_in,
  output logic [NIO-1:0]  io_out,
  output logic [NIO-1:0]  io_oeb,
  output logic [2:0]      user_irq
);

  localparam int HW = NIO - 32;

  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            irq_q, irq_d;
  logic [31:0]     out_lo_q, out_lo_d;
  logic [HW-1:0]   out_hi_q, out_hi_d;
  logic [31:0]     oeb_lo_q, oeb_lo_d;
  logic [HW-1:0]   oeb_hi_q, oeb_hi_d;
  logic [31:0]     irq_en_q, irq_en_d;
  logic [31:0]     irq_stat_q, irq_stat_d;
  logic [NIO-1:0]  sync1_q, sync2_q;
  logic [31:0]     prev_q;

  logic        sel, acc, wr;
  logic [2:0]  ra;
  logic [31:0] wmask, clr, rise, rdata;
  logic        unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  assign sel   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  // The access is taken on the edge that raises ack; the next cycle ack is high and blocks a repeat.
  assign acc   = sel & ~ack_q;
  assign wr    = acc & wbs_we_i;
  assign ra    = wbs_adr_i[4:2];
  assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign rise  = sync2_q[31:0] & ~prev_q;

  always_comb begin
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    oeb_lo_d = oeb_lo_q;
    oeb_hi_d = oeb_hi_q;
    irq_en_d = irq_en_q;
    clr      = '0;
    if (wr) begin
      case (ra)
        3'd0:    out_lo_d = (out_lo_q & ~wmask) | (wbs_dat_i & wmask);
        3'd1:    out_hi_d = (out_hi_q & ~wmask[HW-1:0]) | (wbs_dat_i[HW-1:0] & wmask[HW-1:0]);
        3'd2:    oeb_lo_d = (oeb_lo_q & ~wmask) | (wbs_dat_i & wmask);
        3'd3:    oeb_hi_d = (oeb_hi_q & ~wmask[HW-1:0]) | (wbs_dat_i[HW-1:0] & wmask[HW-1:0]);
        3'd6:    irq_en_d = (irq_en_q & ~wmask) | (wbs_dat_i & wmask);
        3'd7:    clr      = wbs_dat_i & wmask;
        default: clr      = '0;
      endcase
    end
    // A new edge in the same cycle as its W1C must not be lost.
    irq_stat_d = (irq_stat_q & ~clr) | rise;
  end

  always_comb begin
    rdata = '0;
    case (ra)
      3'd0:    rdata = out_lo_q;
      3'd1:    rdata = {{(32-HW){1'b0}}, out_hi_q};
      3'd2:    rdata = oeb_lo_q;
      3'd3:    rdata = {{(32-HW){1'b0}}, oeb_hi_q};
      3'd4:    rdata = sync2_q[31:0];
      3'd5:    rdata = {{(32-HW){1'b0}}, sync2_q[NIO-1:32]};
      3'd6:    rdata = irq_en_q;
      default: rdata = irq_stat_q;
    endcase
    ack_d = acc;
    dat_d = acc ? rdata : 32'h0;
    irq_d = |(irq_stat_q & irq_en_q);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
      out_lo_q   <= '0;
      out_hi_q   <= '0;
      oeb_lo_q   <= '1;
      oeb_hi_q   <= '1;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
      out_lo_q   <= out_lo_d;
      out_hi_q   <= out_hi_d;
      oeb_lo_q   <= oeb_lo_d;
      oeb_hi_q   <= oeb_hi_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      sync1_q    <= io_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q[31:0];
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign user_irq  = {2'b00, irq_q};
  assign io_out    = io_active ? {out_hi_q, out_lo_q} : '0;
  assign io_oeb    = io_active ? {oeb_hi_q, oeb_lo_q} : '1;

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Directed bench for wb_gpio_ctrl: bus access, pad gating, edge interrupts and reset behaviour.
module tb_wb_gpio_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        io_active;
  logic [37:0] io_in, io_out, io_oeb;
  logic [2:0]  user_irq;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] B = 32'h3000_0000;

  wb_gpio_ctrl dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .io_active (io_active),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .user_irq  (user_irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // lat = clock edges from request to ack, -1 if no ack within 10 cycles
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdat, output logic [31:0] rdat, output int lat);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = wdat;
    lat  = -1;
    rdat = '0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        lat  = n - 1;
        rdat = wbs_dat_o;
        break;
      end
    end
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] r;
    int l;
    wb_xfer(adr, 1'b1, sel, d, r, l);
    chk(tag, 64'(l), 64'd1);
  endtask

  task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    int l;
    wb_xfer(adr, 1'b0, 4'hF, 32'h0, r, l);
    chk(tag, {32'(l), r}, {32'd1, exp});
  endtask

  initial begin
    logic [31:0] r;
    int l;
    wb_rst_i = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    io_active = 1'b1;
    io_in = '0;

    repeat (2) @(negedge wb_clk_i);
    chk("rst_ack", 64'(wbs_ack_o), 64'd0);
    chk("rst_dat", 64'(wbs_dat_o), 64'd0);
    chk("rst_irq", 64'(user_irq), 64'd0);
    chk("rst_out", 64'(io_out), 64'd0);
    chk("rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;

    // Reset values and latency
    rd("oeb_lo_rst", B + 32'h08, 32'hFFFF_FFFF);
    chk("oeb_pads", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("dat_idle", 64'(wbs_dat_o), 64'd0);

    // Byte lanes
    wr("wr_out_lo", B + 32'h00, 4'b0011, 32'hA5A5_A5A5);
    rd("out_lo_sel", B + 32'h00, 32'h0000_A5A5);
    chk("out_pads16", 64'(io_out[31:0]), 64'h0000_A5A5);
    wr("wr_out_hi", B + 32'h04, 4'hF, 32'hFFFF_FFFF);
    rd("out_hi_mask", B + 32'h04, 32'h0000_003F);

    // Pad gating
    wr("wr_oeb_lo", B + 32'h08, 4'hF, 32'h0);
    wr("wr_out_lo2", B + 32'h00, 4'hF, 32'hFFFF_FFFF);
    chk("pads_on_out", 64'(io_out), 64'h3F_FFFF_FFFF);
    chk("pads_on_oeb", 64'(io_oeb), 64'h3F_0000_0000);
    io_active = 1'b0; #1;
    chk("gate_out", 64'(io_out), 64'd0);
    chk("gate_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    io_active = 1'b1; #1;
    chk("ungate_out", 64'(io_out[31:0]), 64'hFFFF_FFFF);

    // Inputs, edge capture and W1C byte lanes
    io_in = 38'h15_C3A5_5A50;
    repeat (4) @(posedge wb_clk_i);
    rd("in_lo", B + 32'h10, 32'hC3A5_5A50);
    rd("in_hi", B + 32'h14, 32'h0000_0015);
    wr("wr_ro", B + 32'h10, 4'hF, 32'h0);
    rd("in_lo_ro", B + 32'h10, 32'hC3A5_5A50);
    rd("stat_edges", B + 32'h1C, 32'hC3A5_5A50);
    wr("w1c_b0", B + 32'h1C, 4'b0001, 32'hFFFF_FFFF);
    rd("stat_b0clr", B + 32'h1C, 32'hC3A5_5A00);
    wr("w1c_all", B + 32'h1C, 4'hF, 32'hFFFF_FFFF);
    rd("stat_clr", B + 32'h1C, 32'h0);

    // Interrupt timing on io_in[0]
    wr("wr_irq_en", B + 32'h18, 4'hF, 32'h1);
    @(posedge wb_clk_i); #1 io_in[0] = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("irq_c2", 64'(user_irq), 64'd0);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("irq_c3", 64'(user_irq), 64'd0);
    @(posedge wb_clk_i); #1;
    chk("irq_c4", 64'(user_irq), 64'd1);
    rd("stat_bit0", B + 32'h1C, 32'h1);
    wr("w1c_bit0", B + 32'h1C, 4'hF, 32'h1);
    chk("irq_cleared", 64'(user_irq), 64'd0);

    // Set and clear of bit 3 landing on the same edge
    @(posedge wb_clk_i); #1 io_in[3] = 1'b1;
    @(posedge wb_clk_i);
    wr("w1c_collide", B + 32'h1C, 4'hF, 32'h8);
    rd("stat_setwins", B + 32'h1C, 32'h8);
    wr("w1c_bit3", B + 32'h1C, 4'hF, 32'h8);
    rd("stat_bit3clr", B + 32'h1C, 32'h0);

    // Outside the window
    wb_xfer(B + 32'h100, 1'b1, 4'hF, 32'h1234_5678, r, l);
    chk("oow_noack", 64'(l), 64'hFFFF_FFFF_FFFF_FFFF);
    rd("oow_nochg", B + 32'h00, 32'hFFFF_FFFF);

    // Reset during an acked write
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_adr_i = B; wbs_dat_i = 32'hDEAD_BEEF;
    repeat (2) @(negedge wb_clk_i);
    chk("mid_ack", 64'(wbs_ack_o), 64'd1);
    wb_rst_i = 1'b1; #1;
    chk("mid_ack_drop", 64'(wbs_ack_o), 64'd0);
    chk("mid_out", 64'(io_out), 64'd0);
    chk("mid_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    rd("post_out_lo", B + 32'h00, 32'h0);
    repeat (4) @(posedge wb_clk_i);
    rd("post_edges", B + 32'h1C, 32'hC3A5_5A59);
    rd("post_oeb_hi", B + 32'h0C, 32'h0000_003F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
